cp0_unit: RTL and testbench

//   Coprocessor-0 register file and interrupt controller for the MIPS microsystem. It is the

---
 rtl/cp0_unit.sv | 55 +++++
 tb/tb_cp0_unit.sv | 113 +++++++++++
 2 files changed

// File: rtl/cp0_unit.sv
// cp0_unit: MIPS CP0 SR/Cause/EPC/PRId registers and interrupt request; ports clk, rst, addr/din/we (mfc0/mtc0), pc/exl_set/exl_clr (exception entry/eret), hwint -> int_req, epc_out, dout
module cp0_unit #(
  parameter logic [31:0] PRID      = 32'h2022_0001,
  parameter logic [31:0] EPC_RESET = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  addr,
  input  logic [31:0] din,
  input  logic        we,
  input  logic [31:0] pc,
  input  logic        exl_set,
  input  logic        exl_clr,
  input  logic [5:0]  hwint,
  output logic        int_req,
  output logic [31:0] epc_out,
  output logic [31:0] dout
);
  logic [5:0]  im_q, im_d, ip_q, ip_d;
  logic        ie_q, ie_d, exl_q, exl_d;
  logic [29:0] epc_q, epc_d;
  logic        wr_sr, wr_epc;
  always_comb begin
    wr_sr  = we && addr == 5'd12;
    wr_epc = we && addr == 5'd14;
    im_d   = wr_sr ? din[15:10] : im_q;
    ie_d   = wr_sr ? din[0] : ie_q;
    exl_d  = exl_set ? 1'b1 : exl_clr ? 1'b0 : wr_sr ? din[1] : exl_q;
    epc_d  = exl_set ? pc[31:2] : wr_epc ? din[31:2] : epc_q;
    ip_d   = hwint;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      im_q  <= '0;
      ie_q  <= 1'b0;
      exl_q <= 1'b0;
      ip_q  <= '0;
      epc_q <= EPC_RESET[31:2];
    end else begin
      im_q  <= im_d;
      ie_q  <= ie_d;
      exl_q <= exl_d;
      ip_q  <= ip_d;
      epc_q <= epc_d;
    end
  end
  always_comb begin
    epc_out = {epc_q, 2'b00};
    int_req = |(ip_q & im_q) & ie_q & ~exl_q;
    dout    = addr == 5'd12 ? {16'b0, im_q, 8'b0, exl_q, ie_q} :
              addr == 5'd13 ? {16'b0, ip_q, 10'b0} :
              addr == 5'd14 ? epc_out :
              addr == 5'd15 ? PRID : 32'b0;
  end
endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: directed vector table, hand sequences and randomized model comparison for cp0_unit
module tb_cp0_unit;
  localparam logic [31:0] PRID = 32'h2022_0001;
  localparam logic [31:0] EPCR = 32'h0000_3000;
  logic clk = 0, rst, we, exl_set, exl_clr, int_req;
  logic [4:0] addr;
  logic [31:0] din, pc, epc_out, dout;
  logic [5:0] hwint;
  int checks = 0, errors = 0;
  cp0_unit dut (.clk(clk), .rst(rst), .addr(addr), .din(din), .we(we), .pc(pc),
    .exl_set(exl_set), .exl_clr(exl_clr), .hwint(hwint), .int_req(int_req),
    .epc_out(epc_out), .dout(dout));
  always #5 clk = ~clk;
  typedef struct {
    logic rst, we, es, ec;
    logic [4:0] addr;
    logic [31:0] din, pc;
    logic [5:0] hw;
    logic [4:0] ca;
    logic [31:0] ed, ee;
    logic ei;
  } vec_t;
  vec_t v[18];
  logic [31:0] m_sr, m_cause, m_epc;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", n, a, e, $time);
    end
  endtask
  function automatic logic [31:0] m_read(input logic [4:0] a);
    return a == 12 ? m_sr : a == 13 ? m_cause : a == 14 ? m_epc : a == 15 ? PRID : 32'h0;
  endfunction
  function automatic logic m_int();
    return |(m_cause[15:10] & m_sr[15:10]) & m_sr[0] & ~m_sr[1];
  endfunction
  task automatic m_step();
    if (rst) begin
      m_sr = 0; m_cause = 0; m_epc = EPCR;
    end else begin
      if (we && addr == 12) m_sr = din & 32'h0000_FC03;
      if (exl_set) m_sr[1] = 1'b1;
      else if (exl_clr) m_sr[1] = 1'b0;
      m_epc = exl_set ? (pc & ~32'h3) : (we && addr == 14) ? (din & ~32'h3) : m_epc;
      m_cause = {16'b0, hwint, 10'b0};
    end
  endtask
  initial begin
    rst = 1; we = 0; exl_set = 0; exl_clr = 0; addr = 0; din = 0; pc = 0; hwint = 0;
    //          rst we es ec addr   din            pc             hw  ca  exp dout       exp epc        int
    v[0]  = '{1, 0, 0, 0, 5'd0,  32'h0,        32'h0,        6'd0, 12, 32'h0,        EPCR,         0};
    v[1]  = '{1, 0, 0, 0, 5'd0,  32'h0,        32'h0,        6'd0, 15, PRID,         EPCR,         0};
    v[2]  = '{0, 1, 0, 0, 5'd12, 32'h0000_0401, 32'h0,       6'd0, 12, 32'h0000_0401, EPCR,        0};
    v[3]  = '{0, 0, 0, 0, 5'd0,  32'h0,        32'h0,        6'd1, 13, 32'h0000_0400, EPCR,        1};
    v[4]  = '{0, 0, 1, 0, 5'd0,  32'h0,        32'h0000_3010, 6'd1, 14, 32'h0000_3010, 32'h0000_3010, 0};
    v[5]  = '{0, 0, 0, 0, 5'd0,  32'h0,        32'h0,        6'd1, 12, 32'h0000_0403, 32'h0000_3010, 0};
    v[6]  = '{0, 0, 0, 1, 5'd0,  32'h0,        32'h0,        6'd1, 14, 32'h0000_3010, 32'h0000_3010, 1};
    v[7]  = '{0, 1, 1, 0, 5'd14, 32'h0000_5000, 32'h0000_3020, 6'd1, 14, 32'h0000_3020, 32'h0000_3020, 0};
    v[8]  = '{0, 0, 1, 1, 5'd0,  32'h0,        32'h0000_3030, 6'd1, 12, 32'h0000_0403, 32'h0000_3030, 0};
    v[9]  = '{0, 0, 0, 1, 5'd0,  32'h0,        32'h0,        6'd1, 13, 32'h0000_0400, 32'h0000_3030, 1};
    v[10] = '{0, 1, 0, 0, 5'd13, 32'hFFFF_FFFF, 32'h0,       6'd1, 13, 32'h0000_0400, 32'h0000_3030, 1};
    v[11] = '{0, 1, 0, 0, 5'd14, 32'h0000_3007, 32'h0,       6'd1, 14, 32'h0000_3004, 32'h0000_3004, 1};
    v[12] = '{0, 0, 0, 0, 5'd0,  32'h0,        32'h0,        6'd1, 8,  32'h0,        32'h0000_3004, 1};
    v[13] = '{1, 0, 0, 0, 5'd0,  32'h0,        32'h0,        6'd1, 12, 32'h0,        EPCR,         0};
    v[14] = '{0, 1, 0, 0, 5'd12, 32'h0000_0401, 32'h0,       6'd1, 13, 32'h0000_0400, EPCR,        1};
    v[15] = '{0, 1, 0, 0, 5'd12, 32'h0000_0001, 32'h0,       6'd1, 12, 32'h0000_0001, EPCR,        0};
    v[16] = '{0, 1, 0, 1, 5'd12, 32'h0000_FC03, 32'h0,       6'd1, 12, 32'h0000_FC01, EPCR,        1};
    v[17] = '{0, 1, 1, 0, 5'd12, 32'h0,        32'h0000_3041, 6'd1, 12, 32'h0000_0002, 32'h0000_3040, 0};
    foreach (v[i]) begin
      rst = v[i].rst; we = v[i].we; exl_set = v[i].es; exl_clr = v[i].ec;
      addr = v[i].addr; din = v[i].din; pc = v[i].pc; hwint = v[i].hw;
      @(posedge clk); #1;
      rst = 0; we = 0; exl_set = 0; exl_clr = 0; addr = v[i].ca;
      #1;
      chk($sformatf("vec%0d dout", i), dout, v[i].ed);
      chk($sformatf("vec%0d epc_out", i), epc_out, v[i].ee);
      chk($sformatf("vec%0d int_req", i), {31'b0, int_req}, {31'b0, v[i].ei});
    end
    exl_clr = 1; hwint = 6'b100000; addr = 13; #1;
    chk("eret same-cycle epc_out", epc_out, 32'h0000_3040);
    chk("hwint not yet sampled", dout, 32'h0000_0400);
    @(posedge clk); #1;
    exl_clr = 0;
    chk("hwint sampled next edge", dout, 32'h0000_8000);
    addr = 12; #1;
    chk("sr after eret", dout, 32'h0);
    rst = 1;
    for (int n = 0; n < 3000; n++) begin
      if (n > 0) begin
        rst = ($urandom_range(0, 63) == 0);
        we = $urandom_range(0, 2) == 0;
        exl_set = $urandom_range(0, 9) == 0;
        exl_clr = $urandom_range(0, 7) == 0;
        addr = $urandom_range(0, 3) == 0 ? 5'($urandom) : 5'($urandom_range(11, 16));
        din = $urandom_range(0, 1) ? $urandom : (32'h0000_FC01 & $urandom);
        pc = $urandom;
        hwint = $urandom_range(0, 1) ? 6'($urandom) : 6'd0;
      end
      @(negedge clk);
      if (n > 0) begin
        chk("rand dout", dout, m_read(addr));
        chk("rand epc_out", epc_out, m_epc);
        chk("rand int_req", {31'b0, int_req}, {31'b0, m_int()});
      end
      @(posedge clk);
      m_step();
      #1;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
